// File: rtl/vga_screen_mux.sv
// Purpose: picks start screen, game, or blinking game-over as the source for the VGA pins; debounces the start key; moves START->PLAY->OVER->START.
// Latency: pins are registered, 1 cycle after the selected source. Mode changes land on the frame-boundary cycle.
// Backpressure: none. This is a free-running video stream, and requests that arrive mid-frame wait for the next boundary.
//
// Ports:
//   CLK_40M, RST             - clock and synchronous active-high reset
//   key_start_n              - raw active-low start button (asynchronous)
//   game_over                - one-cycle pulse from the game logic
//   start_* / game_*         - colour and sync from the two upstream sources
//   Vga_*, Hsync_sig, Vsync_sig - registered pin outputs
//   game_en                  - high while in PLAY
//   mode                     - 0=START, 1=PLAY, 2=OVER
module vga_screen_mux #(
    parameter int   DEB_CYCLES   = 800000,
    parameter int   BLINK_FRAMES = 30,
    parameter logic SYNC_ACTIVE  = 1'b0
) (
    input  logic       CLK_40M,
    input  logic       RST,
    input  logic       key_start_n,
    input  logic       game_over,
    input  logic       start_Vga_red,
    input  logic       start_Vga_green,
    input  logic       start_Vga_blue,
    input  logic       start_Hsync_sig,
    input  logic       start_Vsync_sig,
    input  logic       game_Vga_red,
    input  logic       game_Vga_green,
    input  logic       game_Vga_blue,
    input  logic       game_Hsync_sig,
    input  logic       game_Vsync_sig,
    output logic       Vga_red,
    output logic       Vga_green,
    output logic       Vga_blue,
    output logic       Hsync_sig,
    output logic       Vsync_sig,
    output logic       game_en,
    output logic [1:0] mode
);

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PLAY  = 2'd1,
        ST_OVER  = 2'd2
    } state_t;

    state_t           state;
    logic             pending;
    logic [BLK_W-1:0] blink_cnt;
    logic             blink_on;

    // ------------------------------------------------------------------
    // Key synchroniser and debounce.
    // The accepted level resets to "pressed" (0). If the key is held through
    // reset, it therefore matches and cannot produce a press. A released key
    // settles to 1 after one debounce period, and that 0->1 edge emits nothing.
    // ------------------------------------------------------------------
    logic             key_s1;
    logic             key_s2;
    logic             key_acc;
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_mismatch;
    logic             press;

    assign deb_mismatch = (key_s2 != key_acc);
    assign press        = deb_mismatch && (deb_cnt == DEB_LAST) && key_acc;

    always_ff @(posedge CLK_40M) begin
        if (RST) begin
            key_s1  <= 1'b0;
            key_s2  <= 1'b0;
            key_acc <= 1'b0;
            deb_cnt <= '0;
        end else begin
            key_s1 <= key_start_n;
            key_s2 <= key_s1;
            if (!deb_mismatch) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                key_acc <= key_s2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame boundary: the selected source's Vsync enters its active level.
    // Each source keeps its own history register. After a source switch,
    // the new source's edge is therefore judged against its own past and
    // never against the other source.
    // ------------------------------------------------------------------
    logic start_vs_d;
    logic game_vs_d;
    logic sel_vs;
    logic sel_vs_d;
    logic frame_edge;

    always_ff @(posedge CLK_40M) begin
        if (RST) begin
            // Resetting to the active level prevents a false edge when
            // reset releases in the middle of a sync pulse.
            start_vs_d <= SYNC_ACTIVE;
            game_vs_d  <= SYNC_ACTIVE;
        end else begin
            start_vs_d <= start_Vsync_sig;
            game_vs_d  <= game_Vsync_sig;
        end
    end

    assign sel_vs     = (state == ST_START) ? start_Vsync_sig : game_Vsync_sig;
    assign sel_vs_d   = (state == ST_START) ? start_vs_d      : game_vs_d;
    assign frame_edge = (sel_vs == SYNC_ACTIVE) && (sel_vs_d != SYNC_ACTIVE);

    // ------------------------------------------------------------------
    // Sequencer. Only one event matters in each state. In PLAY a press is
    // ignored, so a coincident game_over/press acts as game_over only.
    // ------------------------------------------------------------------
    logic evt;
    logic go;

    always_comb begin
        evt = 1'b0;
        case (state)
            ST_START: evt = press;
            ST_PLAY:  evt = game_over;
            ST_OVER:  evt = press;
            default:  evt = 1'b0;
        endcase
    end

    assign go = frame_edge && (pending || evt);

    always_ff @(posedge CLK_40M) begin
        if (RST) begin
            state     <= ST_START;
            game_en   <= 1'b0;
            pending   <= 1'b0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (go) begin
            pending   <= 1'b0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            case (state)
                ST_START: begin state <= ST_PLAY;  game_en <= 1'b1; end
                ST_PLAY:  begin state <= ST_OVER;  game_en <= 1'b0; end
                default:  begin state <= ST_START; game_en <= 1'b0; end
            endcase
        end else begin
            if (evt) begin
                pending <= 1'b1;
            end
            // The entry boundary starts the first "on" frame, so counting
            // begins with the next boundary.
            if ((state == ST_OVER) && frame_edge) begin
                if (blink_cnt == BLK_LAST) begin
                    blink_cnt <= '0;
                    blink_on  <= !blink_on;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    assign mode = state;

    // ------------------------------------------------------------------
    // Pin register: syncs and colour pass through the same stage.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_40M) begin
        if (RST) begin
            Vga_red   <= 1'b0;
            Vga_green <= 1'b0;
            Vga_blue  <= 1'b0;
            Hsync_sig <= !SYNC_ACTIVE;
            Vsync_sig <= !SYNC_ACTIVE;
        end else begin
            case (state)
                ST_START: begin
                    Vga_red   <= start_Vga_red;
                    Vga_green <= start_Vga_green;
                    Vga_blue  <= start_Vga_blue;
                    Hsync_sig <= start_Hsync_sig;
                    Vsync_sig <= start_Vsync_sig;
                end
                ST_PLAY: begin
                    Vga_red   <= game_Vga_red;
                    Vga_green <= game_Vga_green;
                    Vga_blue  <= game_Vga_blue;
                    Hsync_sig <= game_Hsync_sig;
                    Vsync_sig <= game_Vsync_sig;
                end
                default: begin
                    Vga_red   <= game_Vga_red   && blink_on;
                    Vga_green <= game_Vga_green && blink_on;
                    Vga_blue  <= game_Vga_blue  && blink_on;
                    Hsync_sig <= game_Hsync_sig;
                    Vsync_sig <= game_Vsync_sig;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_screen_mux.sv
// Purpose: scoreboard bench for vga_screen_mux with DEB_CYCLES=16, BLINK_FRAMES=2, SYNC_ACTIVE=0.
// Latency: expectations carry the cycle number at which they must hold, and transitions carry the exact edge they must land on.
// Backpressure: none. The monitor samples on every falling edge.
module tb_vga_screen_mux;

    localparam int FRAME   = 40;
    localparam int END_CYC = 630;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       key_n;
    logic       game_over;
    logic       vga_r, vga_g, vga_b, hs, vs, game_en;
    logic [1:0] mode;

    // cyc = number of rising edges so far; nk = index of the next rising edge.
    int cyc = 0;
    int nk  = 1;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) nk = cyc + 1;

    // Start source: rgb=101, hsync low every 4th cycle, vsync low at frame offsets 0..1.
    // Game source:  rgb=111, hsync low every 5th cycle, vsync low at frame offsets 20..21.
    logic s_hs, s_vs, g_hs, g_vs;
    assign s_hs = (nk % 4) != 0;
    assign s_vs = (nk % FRAME) >= 2;
    assign g_hs = (nk % 5) != 0;
    assign g_vs = !(((nk % FRAME) == 20) || ((nk % FRAME) == 21));

    vga_screen_mux #(
        .DEB_CYCLES  (16),
        .BLINK_FRAMES(2),
        .SYNC_ACTIVE (1'b0)
    ) dut (
        .CLK_40M        (clk),
        .RST            (rst),
        .key_start_n    (key_n),
        .game_over      (game_over),
        .start_Vga_red  (1'b1),
        .start_Vga_green(1'b0),
        .start_Vga_blue (1'b1),
        .start_Hsync_sig(s_hs),
        .start_Vsync_sig(s_vs),
        .game_Vga_red   (1'b1),
        .game_Vga_green (1'b1),
        .game_Vga_blue  (1'b1),
        .game_Hsync_sig (g_hs),
        .game_Vsync_sig (g_vs),
        .Vga_red        (vga_r),
        .Vga_green      (vga_g),
        .Vga_blue       (vga_b),
        .Hsync_sig      (hs),
        .Vsync_sig      (vs),
        .game_en        (game_en),
        .mode           (mode)
    );

    typedef struct {
        int         cyc;
        logic [1:0] mode;
        logic       ge;
        logic [2:0] rgb;
        logic       hs;
        logic       vs;
    } pin_t;

    typedef struct {
        int         cyc;
        logic [1:0] mode;
        logic       ge;
    } tr_t;

    pin_t pin_q[$];
    tr_t  tr_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 1'b0;

    localparam int SRC_RST   = 0;
    localparam int SRC_START = 1;
    localparam int SRC_GAME  = 2;
    localparam int SRC_BLANK = 3;

    // Expected pins after rising edge k, given the source that drove them.
    task automatic push_pin(input int k, input logic [1:0] m, input logic ge, input int src);
        pin_t p;
        p.cyc  = k;
        p.mode = m;
        p.ge   = ge;
        case (src)
            SRC_START: begin p.rgb = 3'b101; p.hs = (k % 4) != 0; p.vs = (k % FRAME) >= 2; end
            SRC_GAME, SRC_BLANK: begin
                p.rgb = (src == SRC_GAME) ? 3'b111 : 3'b000;
                p.hs  = (k % 5) != 0;
                p.vs  = !(((k % FRAME) == 20) || ((k % FRAME) == 21));
            end
            default: begin p.rgb = 3'b000; p.hs = 1'b1; p.vs = 1'b1; end
        endcase
        pin_q.push_back(p);
    endtask

    task automatic push_tr(input int k, input logic [1:0] m, input logic ge);
        tr_t t;
        t.cyc  = k;
        t.mode = m;
        t.ge   = ge;
        tr_q.push_back(t);
    endtask

    // Return at the falling edge just before rising edge k, so that drives land on edge k.
    task automatic drive_at(input int k);
        while (cyc < k - 1) @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Monitor: the only process that steps checks/failures.
    // ------------------------------------------------------------------
    logic [1:0] prev_mode;
    logic       prev_ge;
    bit         armed = 1'b0;
    pin_t       pe;
    tr_t        te;

    function automatic void chk(input string name, input int act, input int exp_v, input int c);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, c, act, exp_v);
        end
    endfunction

    always @(negedge clk) begin
        if (cyc >= 3) begin
            if (armed && ({mode, game_en} !== {prev_mode, prev_ge})) begin
                if (tr_q.size() == 0) begin
                    chk("unexpected_transition", int'(mode), int'(prev_mode), cyc);
                end else begin
                    te = tr_q.pop_front();
                    chk("transition_cycle", cyc, te.cyc, cyc);
                    chk("transition_mode", int'(mode), int'(te.mode), cyc);
                    chk("transition_game_en", int'(game_en), int'(te.ge), cyc);
                end
            end
            prev_mode = mode;
            prev_ge   = game_en;
            armed     = 1'b1;
        end
        while ((pin_q.size() > 0) && (pin_q[0].cyc <= cyc)) begin
            pe = pin_q.pop_front();
            chk("pin_sample_cycle", cyc, pe.cyc, cyc);
            chk("mode", int'(mode), int'(pe.mode), cyc);
            chk("game_en", int'(game_en), int'(pe.ge), cyc);
            chk("rgb", int'({vga_r, vga_g, vga_b}), int'(pe.rgb), cyc);
            chk("hsync", int'(hs), int'(pe.hs), cyc);
            chk("vsync", int'(vs), int'(pe.vs), cyc);
        end
        if (cyc == END_CYC && !done) begin
            chk("missing_transitions", tr_q.size(), 0, cyc);
            chk("unchecked_pin_samples", pin_q.size(), 0, cyc);
            done = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus. Start boundaries are at edges k%40==0, and game boundaries at k%40==20.
    // A key held low from edge k0 is accepted as a press at edge k0+17.
    // ------------------------------------------------------------------
    initial begin
        rst       = 1'b1;
        key_n     = 1'b1;
        game_over = 1'b0;

        // Reset for edges 1..3.
        push_pin(3, 2'd0, 1'b0, SRC_RST);
        drive_at(4);
        rst = 1'b0;

        // Glitch of 10 cycles: no press, and no transition at boundary 40.
        push_pin(45, 2'd0, 1'b0, SRC_START);
        drive_at(30); key_n = 1'b0;
        drive_at(40); key_n = 1'b1;

        // Press accepted at 67 (mid-frame). PLAY at start boundary 80, then game pins from 81.
        push_pin(79, 2'd0, 1'b0, SRC_START);
        push_tr(80, 2'd1, 1'b1);
        push_pin(80, 2'd1, 1'b1, SRC_START);
        push_pin(81, 2'd1, 1'b1, SRC_GAME);
        drive_at(50); key_n = 1'b0;
        drive_at(90); key_n = 1'b1;

        // game_over and press coincide at 130. OVER follows at game boundary 140.
        push_pin(139, 2'd1, 1'b1, SRC_GAME);
        push_tr(140, 2'd2, 1'b0);
        push_pin(141, 2'd2, 1'b0, SRC_GAME);
        drive_at(113); key_n = 1'b0;
        drive_at(130); game_over = 1'b1;
        drive_at(131); game_over = 1'b0;
        drive_at(150); key_n = 1'b1;

        // Blink: on for frames starting 140/180, off from 220/260, on again from 300.
        push_pin(150, 2'd2, 1'b0, SRC_GAME);
        push_pin(200, 2'd2, 1'b0, SRC_GAME);
        push_pin(219, 2'd2, 1'b0, SRC_GAME);
        push_pin(225, 2'd2, 1'b0, SRC_BLANK);
        push_pin(230, 2'd2, 1'b0, SRC_BLANK);
        push_pin(260, 2'd2, 1'b0, SRC_BLANK);
        push_pin(299, 2'd2, 1'b0, SRC_BLANK);
        push_pin(305, 2'd2, 1'b0, SRC_GAME);
        push_pin(310, 2'd2, 1'b0, SRC_GAME);

        // Press accepted at 337. START follows at game boundary 340.
        push_pin(339, 2'd2, 1'b0, SRC_GAME);
        push_tr(340, 2'd0, 1'b0);
        push_pin(341, 2'd0, 1'b0, SRC_START);
        drive_at(320); key_n = 1'b0;
        drive_at(360); key_n = 1'b1;

        // Press accepted at 397. PLAY follows at start boundary 400.
        push_tr(400, 2'd1, 1'b1);
        drive_at(380); key_n = 1'b0;
        drive_at(420); key_n = 1'b1;

        // A game_over is pending when reset arrives at 445, with the key held low through reset.
        push_pin(444, 2'd1, 1'b1, SRC_GAME);
        push_tr(445, 2'd0, 1'b0);
        push_pin(445, 2'd0, 1'b0, SRC_RST);
        push_pin(450, 2'd0, 1'b0, SRC_START);
        push_pin(520, 2'd0, 1'b0, SRC_START);
        push_pin(599, 2'd0, 1'b0, SRC_START);
        push_tr(600, 2'd1, 1'b1);
        push_pin(601, 2'd1, 1'b1, SRC_GAME);
        drive_at(430); game_over = 1'b1;
        drive_at(431); game_over = 1'b0;
        drive_at(440); key_n = 1'b0;
        drive_at(445); rst = 1'b1;
        drive_at(447); rst = 1'b0;
        // Release, then a fresh press accepted at 577. PLAY follows at start boundary 600.
        drive_at(530); key_n = 1'b1;
        drive_at(560); key_n = 1'b0;
        drive_at(620); key_n = 1'b1;

        while (!done && cyc < END_CYC + 20) @(negedge clk);
        if (!done) begin
            $display("FAIL monitor_end cyc=%0d actual=not_done expected=done", cyc);
            $fatal(1, "monitor did not complete");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
